// File: rtl/pe_packetizer.sv
// PE-side packetizer: buffers neuron payloads in a small circular FIFO and
// presents them to the router PE port with the node's X/Y coordinates as header.
module pe_packetizer #(
   parameter int          packet_size = 16,
   parameter int unsigned x           = 2'd1,
   parameter int unsigned y           = 2'd1,
   parameter int          xno_switch  = 4,
   parameter int          yno_switch  = 4,
   parameter int          DEPTH       = 4,
   localparam int         XW          = $clog2(xno_switch),
   localparam int         YW          = $clog2(yno_switch),
   localparam int         DW          = packet_size - XW - YW,
   localparam int         CW          = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   i_reset,
   input  logic [DW-1:0]          i_data,
   input  logic                   i_valid,
   output logic [packet_size-1:0] o_data,
   output logic                   o_wr_valid,
   input  logic                   i_fifoReady,
   output logic [CW-1:0]          o_count,
   output logic                   o_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [XW-1:0] XH = x[XW-1:0];
   localparam logic [YW-1:0] YH = y[YW-1:0];

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic          full, push, pop, drop;

   assign full = (count == CW'(DEPTH));
   assign pop  = o_wr_valid & i_fifoReady;
   // A full buffer still accepts when the head leaves at the same edge.
   assign push = i_valid & (~full | pop);
   assign drop = i_valid & full & ~pop;

   always_ff @(posedge clk) begin
      if (!i_reset && push) mem[wr_ptr] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         state    <= IDLE;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (drop) overflow <= 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         case (state)
            IDLE: if (push) state <= SEND;
            SEND: if (pop && !push && count == CW'(1)) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs come only from registered state; data is zeroed while idle.
   assign o_wr_valid = (state == SEND);
   assign o_data     = o_wr_valid ? {XH, YH, mem[rd_ptr]} : '0;
   assign o_count    = count;
   assign o_overflow = overflow;

endmodule

// File: tb/tb_pe_packetizer.sv
// Randomized + directed bench for pe_packetizer with a queue-based reference
// model and a negedge monitor comparing every presented packet.
module tb_pe_packetizer;
   localparam int PS = 16, XV = 1, YV = 1, DEPTH = 4;
   localparam int XW = 2, YW = 2, DW = PS - XW - YW, CW = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          i_reset = 1'b1;
   logic [DW-1:0] i_data = '0;
   logic          i_valid = 1'b0;
   logic          i_fifoReady = 1'b0;
   logic [PS-1:0] o_data;
   logic          o_wr_valid;
   logic [CW-1:0] o_count;
   logic          o_overflow;

   int total = 0, bad = 0;
   bit armed = 0;

   // reference model: expected packets in acceptance order
   logic [PS-1:0] exp_q[$];
   int            mcount = 0;
   bit            movf = 0;

   pe_packetizer #(.packet_size(PS), .x(XV), .y(YV), .xno_switch(4),
                   .yno_switch(4), .DEPTH(DEPTH)) dut (
      .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
      .o_data(o_data), .o_wr_valid(o_wr_valid), .i_fifoReady(i_fifoReady),
      .o_count(o_count), .o_overflow(o_overflow));

   always #5 clk = ~clk;

   function automatic logic [PS-1:0] pkt(input logic [DW-1:0] d);
      return PS'((XV << (DW + YW)) | (YV << DW)) | PS'(d);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Model: decides accept/drop/pop from its own occupancy each edge.
   always @(posedge clk) begin
      if (i_reset) begin
         mcount = 0;
         movf   = 0;
         exp_q.delete();
      end else begin
         bit p, q;
         q = (mcount > 0) && i_fifoReady;
         p = i_valid && (mcount < DEPTH || q);
         if (i_valid && !p) movf = 1;
         if (p) exp_q.push_back(pkt(i_data));
         mcount = mcount + int'(p) - int'(q);
      end
   end

   // Monitor: compares presented state and retires the head on handshake.
   always @(negedge clk) begin
      if (armed) begin
         chk("count", 32'(o_count), 32'(mcount));
         chk("valid", 32'(o_wr_valid), 32'(mcount != 0));
         chk("overflow", 32'(o_overflow), 32'(movf));
         if (o_wr_valid) begin
            if (exp_q.size() == 0) chk("unexpected_pkt", 32'(o_data), 32'hFFFF_FFFF);
            else begin
               chk("pkt_data", 32'(o_data), 32'(exp_q[0]));
               if (i_fifoReady) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic drive(input bit v, input logic [DW-1:0] d, input bit r, input bit rst = 0);
      i_valid = v; i_data = d; i_fifoReady = r; i_reset = rst;
      @(posedge clk); #1;
   endtask

   initial begin
      #1;
      repeat (3) drive(0, '0, 0, 1);
      armed = 1;
      drive(0, '0, 0);
      chk("rst_valid", 32'(o_wr_valid), 0);
      chk("rst_count", 32'(o_count), 0);
      chk("rst_ovf", 32'(o_overflow), 0);
      chk("rst_data", 32'(o_data), 0);

      // single packet, one-cycle latency
      drive(1, 12'hABC, 1);
      chk("lat_valid", 32'(o_wr_valid), 1);
      chk("lat_data", 32'(o_data), 32'h5ABC);
      drive(0, '0, 1);
      chk("after_valid", 32'(o_wr_valid), 0);
      chk("after_count", 32'(o_count), 0);

      // fill under backpressure, then drain in order
      for (int k = 1; k <= 4; k++) drive(1, DW'(k), 0);
      chk("fill_count", 32'(o_count), 4);
      chk("fill_head", 32'(o_data), 32'h5001);
      drive(0, '0, 0);
      chk("hold_head", 32'(o_data), 32'h5001);
      for (int k = 1; k <= 4; k++) begin
         i_fifoReady = 1;
         #1 chk("drain_seq", 32'(o_data), 32'h5000 + 32'(k));
         drive(0, '0, 1);
      end
      chk("drain_empty", 32'(o_count), 0);

      // overflow when full without a pop
      for (int k = 0; k < 4; k++) drive(1, DW'(12'h021 + k), 0);
      drive(1, 12'h0FF, 0);
      chk("ovf_set", 32'(o_overflow), 1);
      chk("ovf_count", 32'(o_count), 4);
      for (int k = 0; k < 4; k++) begin
         i_fifoReady = 1;
         #1 chk("ovf_drain", 32'(o_data), 32'h5021 + 32'(k));
         drive(0, '0, 1);
      end
      chk("ovf_sticky", 32'(o_overflow), 1);

      // full with simultaneous push/pop: no drop
      drive(0, '0, 0, 1);
      for (int k = 0; k < 4; k++) drive(1, DW'(12'h030 + k), 0);
      for (int k = 0; k < 8; k++) begin
         drive(1, DW'(12'h010 + k), 1);
         chk("pp_count", 32'(o_count), 4);
         chk("pp_ovf", 32'(o_overflow), 0);
      end
      for (int k = 0; k < 4; k++) drive(0, '0, 1);
      chk("pp_empty", 32'(o_count), 0);

      // reset mid-transfer discards buffered packets
      drive(1, 12'h111, 0);
      drive(1, 12'h222, 0);
      drive(0, '0, 0, 1);
      chk("mrst_valid", 32'(o_wr_valid), 0);
      chk("mrst_count", 32'(o_count), 0);
      chk("mrst_ovf", 32'(o_overflow), 0);
      chk("mrst_data", 32'(o_data), 0);
      drive(1, 12'h123, 0);
      chk("post_rst_count", 32'(o_count), 1);
      chk("post_rst_data", 32'(o_data), 32'h5123);
      drive(0, '0, 1);
      chk("post_rst_empty", 32'(o_count), 0);

      // random traffic with occasional reset
      for (int n = 0; n < 10000; n++) begin
         drive($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
               $urandom_range(0, 999) == 0);
      end
      repeat (DEPTH + 2) drive(0, '0, 1);
      chk("final_empty", 32'(exp_q.size()), 0);

      armed = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pe_packetizer.md
PE_PACKETIZER -- requirements
Module: pe_packetizer

Interface
- REQ-001: Parameter packet_size, default 16: width of one NoC packet.
- REQ-002: Parameter x, default 2'd1: X coordinate of this node, used as header field.
- REQ-003: Parameter y, default 2'd1: Y coordinate of this node, used as header field.
- REQ-004: Parameter xno_switch, default 4: mesh switches in X; header X width is XW = $clog2(xno_switch).
- REQ-005: Parameter yno_switch, default 4: mesh switches in Y; header Y width is YW = $clog2(yno_switch).
- REQ-006: Parameter DEPTH, default 4, power of two, minimum 2: payload buffer entries.
- REQ-007: Derived DW = packet_size-XW-YW: payload width.
- REQ-008: clk, input, 1: single clock; all state updates on rising edge.
- REQ-009: i_reset, input, 1: synchronous, active-high reset.
- REQ-010: i_data, input, DW: neuron result payload.
- REQ-011: i_valid, input, 1: i_data valid this cycle; no backpressure toward the source.
- REQ-012: o_data, output, packet_size: packet to router PE input.
- REQ-013: o_wr_valid, output, 1: o_data holds a packet; drives router i_wr_valid_PE.
- REQ-014: i_fifoReady, input, 1: router PE FIFO not full; driven from router o_wr_fifoReady_PE.
- REQ-015: o_count, output, $clog2(DEPTH+1): buffered packets, including the one presented.
- REQ-016: o_overflow, output, 1: sticky flag; a payload was dropped.

Function
- REQ-017: Packet format SHALL be o_data = {x[XW-1:0], y[YW-1:0], payload[DW-1:0]}, with header in the MSBs.
- REQ-018: Buffer SHALL be a circular FIFO of DEPTH entries with read and write pointers that wrap modulo DEPTH and a separate occupancy counter.
- REQ-019: Push SHALL occur at an edge where i_valid=1 and the buffer is not full, or is full with a pop in the same cycle.
- REQ-020: Pop SHALL occur at an edge where o_wr_valid=1 and i_fifoReady=1.
- REQ-021: o_wr_valid SHALL equal (o_count != 0); o_data SHALL be the head entry; both SHALL be registered or derived only from registered state, with no combinational path from i_valid or i_data.
- REQ-022: Latency SHALL be one cycle: a payload pushed into an empty buffer at edge N SHALL appear with o_wr_valid=1 in cycle N+1.
- REQ-023: While o_wr_valid=1 and i_fifoReady=0, o_data SHALL hold stable.
- REQ-024: Push and pop at the same edge SHALL leave o_count unchanged and advance both pointers.
- REQ-025: Full (o_count=DEPTH) with i_valid=1 and no pop: payload SHALL be dropped, o_overflow SHALL be set, and state SHALL be otherwise unchanged.
- REQ-026: Full with push and pop at the same edge SHALL accept the payload with no overflow.
- REQ-027: Empty with i_fifoReady=1 SHALL produce no pop and leave o_wr_valid=0.
- REQ-028: Control SHALL be a two-state machine: IDLE (o_count=0) and SEND (o_count>0). IDLE->SEND on push; SEND->IDLE on pop with o_count=1 and no push; otherwise the state holds.
- REQ-029: Packets SHALL leave in acceptance order; none SHALL be duplicated or reordered.
- REQ-030: o_overflow SHALL clear only on reset.

Reset
- REQ-031: While i_reset=1 at an edge: pointers=0, o_count=0, state=IDLE, o_wr_valid=0, o_overflow=0, and o_data=0; inputs are ignored.
- REQ-032: Reset asserted mid-transfer SHALL discard all buffered packets; no packet is emitted until a new push after reset.
- REQ-033: The first push SHALL be accepted on the first edge with i_reset=0.

Verification (defaults: x=1, y=1, DW=12)
- REQ-034: Reset, then i_valid=1 with i_data=12'hABC for one cycle and i_fifoReady=1 -> next cycle o_wr_valid=1 and o_data=16'h5ABC; the following cycle o_wr_valid=0 and o_count=0.
- REQ-035: i_fifoReady=0; push 12'h001..12'h004 -> o_count=4, o_data=16'h5001 stable; raise i_fifoReady -> 16'h5001..16'h5004 emitted on four consecutive cycles.
- REQ-036: Full buffer, i_fifoReady=0, push 12'h0FF -> o_overflow=1, o_count=4, and 12'h0FF is never emitted.
- REQ-037: Full buffer, i_fifoReady=1, i_valid=1 continuously with 12'h010,12'h011,... -> o_count stays 4, o_overflow stays 0, and output order is preserved.
- REQ-038: Two packets buffered, assert i_reset for one cycle -> o_wr_valid=0, o_count=0, o_overflow=0; a later push of 12'h123 -> 16'h5123 emitted alone.
- REQ-039: Random i_valid/i_fifoReady for 10k cycles -> scoreboard confirms in-order delivery, drops only when full without a pop, and o_count equals pushes minus pops.
